// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests
// to instruction memory, buffers in-order responses and presents them to decode.
// Wrong-path responses that are still in flight after a redirect are discarded.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a redirect to a target that is not
// word aligned sets a sticky error flag and halts fetch until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Branch_Taken_E,
  input  logic [31:0] PC_Target_E,
  output logic        IMEM_Req_Valid,
  output logic [31:0] IMEM_Req_Addr,
  input  logic        IMEM_Req_Ready,
  input  logic        IMEM_Resp_Valid,
  input  logic [31:0] IMEM_Resp_Data,
  output logic        Instr_Valid_F,
  input  logic        Instr_Ready_F,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus4_F,
  output logic        Misalign_Err_F
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      data_mem_q [FIFO_DEPTH];
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];

  logic [31:0] redirect_tgt;
  logic        halted;
  logic        credit_ok;
  logic        accept;
  logic        resp_ok;
  logic        push;
  logic        pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Misaligned targets are kept as-is; the sticky flag stops all further fetching.
  assign redirect_tgt   = PC_Target_E;
  assign halted         = misalign_q;
  assign Misalign_Err_F = misalign_q;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_comb begin
    misalign_d = misalign_q;
    if (Branch_Taken_E && (PC_Target_E[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  // Misalign flag register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  // Without the check the target is silently word aligned.
  assign redirect_tgt   = PC_Target_E & 32'hFFFF_FFFC;
  assign halted         = 1'b0;
  assign Misalign_Err_F = 1'b0;
`endif

  // Wrap a FIFO pointer modulo the buffer depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Request only when a buffer slot is guaranteed for every in-flight word.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < CREDITS;

  assign IMEM_Req_Valid = !RST && !Branch_Taken_E && !halted && credit_ok;
  assign IMEM_Req_Addr  = fetch_pc_q;
  assign accept         = IMEM_Req_Valid && IMEM_Req_Ready;

  // A response with nothing outstanding is ignored.
  assign resp_ok = IMEM_Resp_Valid && (outst_q != '0);
  assign push    = resp_ok && (drop_q == '0) && !Branch_Taken_E && !RST;

  assign Instr_Valid_F = !RST && !Branch_Taken_E && (count_q != '0);
  assign Instr_F       = data_mem_q[rd_ptr_q];
  assign PC_F          = pc_mem_q[rd_ptr_q];
  assign PC_Plus4_F    = pc_mem_q[rd_ptr_q] + 32'd4;
  assign pop           = Instr_Valid_F && Instr_Ready_F;

  // Next-state for PCs, credit counters and FIFO control; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (accept && !resp_ok) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!accept && resp_ok) begin
      outst_d = outst_q - CNT_W'(1);
    end

    if (resp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (push) begin
      wr_ptr_d  = ptr_inc(wr_ptr_q);
      resp_pc_d = resp_pc_q + 32'd4;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    if (Branch_Taken_E) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_d     = outst_d;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Instruction buffer storage; contents are qualified by count_q so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= IMEM_Resp_Data;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // Memory must never respond without an outstanding request.
  a_resp_has_credit : assert property (
    @(posedge CLK) disable iff (RST) IMEM_Resp_Valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with programmable latency
// and a scoreboard of expected fetch PCs that is flushed on every redirect.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Branch_Taken_E;
  logic [31:0] PC_Target_E;
  logic        IMEM_Req_Valid;
  logic [31:0] IMEM_Req_Addr;
  logic        IMEM_Req_Ready;
  logic        IMEM_Resp_Valid;
  logic [31:0] IMEM_Resp_Data;
  logic        Instr_Valid_F;
  logic        Instr_Ready_F;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_Plus4_F;
  logic        Misalign_Err_F;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Branch_Taken_E (Branch_Taken_E),
    .PC_Target_E    (PC_Target_E),
    .IMEM_Req_Valid (IMEM_Req_Valid),
    .IMEM_Req_Addr  (IMEM_Req_Addr),
    .IMEM_Req_Ready (IMEM_Req_Ready),
    .IMEM_Resp_Valid(IMEM_Resp_Valid),
    .IMEM_Resp_Data (IMEM_Resp_Data),
    .Instr_Valid_F  (Instr_Valid_F),
    .Instr_Ready_F  (Instr_Ready_F),
    .Instr_F        (Instr_F),
    .PC_F           (PC_F),
    .PC_Plus4_F     (PC_Plus4_F),
    .Misalign_Err_F (Misalign_Err_F)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          first_acc;
  int          first_vld;
  logic        saw_wrap;
  logic        last_req_valid;
  logic [31:0] exp_req_addr;
  logic [31:0] mq_addr [$];
  int          mq_rdy  [$];
  logic [31:0] sb_pc   [$];
  logic [31:0] acc_log [$];
  logic [31:0] pop_log [$];

  // Memory contents: an address-dependent pattern so PC/data pairing is checkable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive memory response, observe, update models, advance.
  task automatic step();
    logic acc, pop, rsp;
    logic [31:0] e;
    if (!RST && (mq_addr.size() != 0) && (mq_rdy[0] <= cyc)) begin
      IMEM_Resp_Valid = 1'b1;
      IMEM_Resp_Data  = mem_word(mq_addr[0]);
    end else begin
      IMEM_Resp_Valid = 1'b0;
      IMEM_Resp_Data  = 32'h0;
    end
    #1;
    acc = IMEM_Req_Valid & IMEM_Req_Ready;
    pop = Instr_Valid_F & Instr_Ready_F;
    rsp = IMEM_Resp_Valid;
    last_req_valid = IMEM_Req_Valid;

    if (RST) begin
      check_eq("rst_req_valid", 32'(IMEM_Req_Valid), 32'd0);
      check_eq("rst_instr_valid", 32'(Instr_Valid_F), 32'd0);
    end
    if (Branch_Taken_E) begin
      check_eq("redirect_req_valid", 32'(IMEM_Req_Valid), 32'd0);
      check_eq("redirect_instr_valid", 32'(Instr_Valid_F), 32'd0);
    end
    if (Instr_Valid_F && first_vld < 0) first_vld = cyc;

    if (pop) begin
      check_eq("pop_has_expectation", 32'(sb_pc.size() != 0), 32'd1);
      if (sb_pc.size() != 0) begin
        e = sb_pc.pop_front();
        check_eq("pc_f", PC_F, e);
        check_eq("instr_f", Instr_F, mem_word(e));
        check_eq("pc_plus4_f", PC_Plus4_F, e + 32'd4);
        if (e == 32'hFFFF_FFFC) begin
          check_eq("wrap_pc_plus4", PC_Plus4_F, 32'h0000_0000);
          saw_wrap = 1'b1;
        end
      end
      pop_log.push_back(PC_F);
    end

    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end

    if (acc) begin
      check_eq("req_addr", IMEM_Req_Addr, exp_req_addr);
      acc_log.push_back(IMEM_Req_Addr);
      if (first_acc < 0) first_acc = cyc;
      mq_addr.push_back(IMEM_Req_Addr);
      mq_rdy.push_back(cyc + mem_lat);
      sb_pc.push_back(exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
    end

    if (Branch_Taken_E) begin
      sb_pc.delete();
      exp_req_addr = PC_Target_E & 32'hFFFF_FFFC;
    end
    if (RST) begin
      mq_addr.delete();
      mq_rdy.delete();
      sb_pc.delete();
      exp_req_addr = RST_PC;
    end

    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) step();
    check_eq("rst_misalign", 32'(Misalign_Err_F), 32'd0);
    check_eq("rst_instr_valid_after_edge", 32'(Instr_Valid_F), 32'd0);
    RST = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    Branch_Taken_E = 1'b1;
    PC_Target_E    = tgt;
    step();
    Branch_Taken_E = 1'b0;
  endtask

  // Stop issuing, let everything in flight land and be consumed.
  task automatic drain();
    IMEM_Req_Ready = 1'b0;
    Instr_Ready_F  = 1'b1;
    repeat (12) step();
    check_eq("drain_sb_empty", 32'(sb_pc.size()), 32'd0);
    check_eq("drain_mem_idle", 32'(mq_addr.size()), 32'd0);
    check_eq("drain_no_valid", 32'(Instr_Valid_F), 32'd0);
    IMEM_Req_Ready = 1'b1;
  endtask

  initial begin
    RST             = 1'b1;
    Branch_Taken_E  = 1'b0;
    PC_Target_E     = 32'h0;
    IMEM_Req_Ready  = 1'b1;
    IMEM_Resp_Valid = 1'b0;
    IMEM_Resp_Data  = 32'h0;
    Instr_Ready_F   = 1'b1;
    first_acc       = -1;
    first_vld       = -1;
    saw_wrap        = 1'b0;
    last_req_valid  = 1'b0;
    exp_req_addr    = RST_PC;
    @(negedge CLK);

    // Streaming after reset with a 1-cycle memory.
    do_reset();
    acc_log.delete(); pop_log.delete();
    first_acc = -1; first_vld = -1;
    repeat (12) step();
    check_eq("t1_acc0", q_at(acc_log, 0), 32'h0000_0100);
    check_eq("t1_acc1", q_at(acc_log, 1), 32'h0000_0104);
    check_eq("t1_acc2", q_at(acc_log, 2), 32'h0000_0108);
    check_eq("t1_latency", 32'(first_vld - first_acc), 32'd2);
    check_eq("t1_first_pc", q_at(pop_log, 0), 32'h0000_0100);

    // Decode stall: credit limits acceptance to the buffer depth.
    do_reset();
    Instr_Ready_F = 1'b0;
    acc_log.delete(); pop_log.delete();
    repeat (10) step();
    check_eq("t2_accepts", 32'(acc_log.size()), 32'd2);
    check_eq("t2_req_valid_low", 32'(last_req_valid), 32'd0);
    Instr_Ready_F = 1'b1;
    repeat (10) step();
    check_eq("t2_pop0", q_at(pop_log, 0), 32'h0000_0100);
    check_eq("t2_pop1", q_at(pop_log, 1), 32'h0000_0104);
    check_eq("t2_pop2", q_at(pop_log, 2), 32'h0000_0108);

    // Redirect with two requests outstanding.
    mem_lat = 3;
    for (int i = 0; i < 20 && mq_addr.size() != 2; i++) step();
    check_eq("t3_two_outstanding", 32'(mq_addr.size()), 32'd2);
    pop_log.delete();
    redirect(32'h0000_0400);
    repeat (15) step();
    check_eq("t3_first_pc", q_at(pop_log, 0), 32'h0000_0400);
    drain();

    // Response coincident with redirect while a request is pending.
    mem_lat = 2;
    acc_log.delete();
    step();
    check_eq("t4_one_accept", 32'(acc_log.size()), 32'd1);
    IMEM_Req_Ready = 1'b0;
    step();
    check_eq("t4_pending_req", 32'(last_req_valid), 32'd1);
    check_eq("t4_resp_due", 32'((mq_rdy.size() != 0) && (mq_rdy[0] <= cyc)), 32'd1);
    redirect(32'h0000_0800);
    IMEM_Req_Ready = 1'b1;
    acc_log.delete(); pop_log.delete();
    repeat (10) step();
    check_eq("t4_next_req", q_at(acc_log, 0), 32'h0000_0800);
    check_eq("t4_first_pc", q_at(pop_log, 0), 32'h0000_0800);

    // Address wrap at the top of the address space.
    mem_lat = 1;
    acc_log.delete();
    redirect(32'hFFFF_FFF8);
    repeat (12) step();
    check_eq("t5_acc0", q_at(acc_log, 0), 32'hFFFF_FFF8);
    check_eq("t5_acc1", q_at(acc_log, 1), 32'hFFFF_FFFC);
    check_eq("t5_acc2", q_at(acc_log, 2), 32'h0000_0000);
    check_eq("t5_saw_wrap", 32'(saw_wrap), 32'd1);

    // Misaligned redirect target.
    acc_log.delete(); pop_log.delete();
    redirect(32'h0000_0402);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("t6_misalign_set", 32'(Misalign_Err_F), 32'd1);
    repeat (10) step();
    check_eq("t6_no_requests", 32'(acc_log.size()), 32'd0);
    check_eq("t6_misalign_sticky", 32'(Misalign_Err_F), 32'd1);
    do_reset();
    repeat (6) step();
    check_eq("t6_refetch_after_reset", q_at(acc_log, 0), RST_PC);
`else
    repeat (10) step();
    check_eq("t6_aligned_req", q_at(acc_log, 0), 32'h0000_0400);
    check_eq("t6_aligned_pc", q_at(pop_log, 0), 32'h0000_0400);
    check_eq("t6_misalign_zero", 32'(Misalign_Err_F), 32'd0);
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
